// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: eight single-cycle modes plus an N-step auto-shift sequencer.
// Single-cycle ops land 1 cycle after enable; an accepted start keeps busy high for exactly N cycles, then done pulses once.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_INV  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [2:0]       run_mode_q, run_mode_d;
  logic             done_q, done_d;
  logic             start_ok;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] ld,
    input logic             sin_l,
    input logic             sin_r
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (op)
      MODE_HOLD: r = q;
      MODE_LOAD: r = ld;
      MODE_SHL:  r = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  r = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  r = {q[0], q[WIDTH-1:1]};
      MODE_CLR:  r = '0;
      MODE_INV:  r = ~q;
      default:   r = q;
    endcase
    return r;
  endfunction

  // Only shift/rotate modes with a non-zero count start a sequence.
  assign start_ok = (mode >= MODE_SHL) && (mode <= MODE_ROR) && (shift_cnt != '0);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    run_mode_d  = run_mode_q;
    done_d      = 1'b0;
    if (state_q == RUN) begin
      data_d      = apply_op(run_mode_q, data_q, data_in, ser_in_l, ser_in_r);
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      if (start_ok) begin
        state_d     = RUN;
        run_mode_d  = mode;
        remaining_d = shift_cnt;
      end else begin
        done_d = 1'b1;
      end
    end else if (enable) begin
      data_d = apply_op(mode, data_q, data_in, ser_in_l, ser_in_r);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      remaining_q <= '0;
      run_mode_q  <= MODE_HOLD;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      run_mode_q  <= run_mode_d;
      done_q      <= done_d;
    end
  end

  assign data_out  = data_q;
  assign ser_out_l = data_q[WIDTH-1];
  assign ser_out_r = data_q[0];
  assign busy      = (state_q == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8, CNT_W=4); inputs change and outputs are sampled on the falling edge.
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] data_in = 8'h00;
  logic       ser_in_l = 1'b0;
  logic       ser_in_r = 1'b0;
  logic       start = 1'b0;
  logic [3:0] shift_cnt = 4'd0;
  logic [7:0] data_out;
  logic       ser_out_l, ser_out_r, busy, done;

  int errors = 0;
  int checks = 0;

  universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .data_in(data_in),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start), .shift_cnt(shift_cnt),
    .data_out(data_out), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    enable = 1'b1; mode = 3'b001; data_in = v;
    step();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    step();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_hold: got %h want 00", data_out); end
  endtask

  task automatic test_load_hold();
    load(8'hAA);
    checks++; if (data_out !== 8'hAA) begin errors++; $display("FAIL load: got %h want AA", data_out); end
    data_in = 8'h55;
    step();
    checks++; if (data_out !== 8'hAA) begin errors++; $display("FAIL hold: got %h want AA", data_out); end
    checks++; if (ser_out_l !== 1'b1) begin errors++; $display("FAIL ser_out_l: got %b want 1", ser_out_l); end
    checks++; if (ser_out_r !== 1'b0) begin errors++; $display("FAIL ser_out_r: got %b want 0", ser_out_r); end
  endtask

  task automatic test_modes();
    logic [7:0] init [6];
    logic [2:0] md   [6];
    logic       sl   [6];
    logic       sr   [6];
    logic [7:0] exp  [6];
    init[0] = 8'hAA; md[0] = 3'b010; sl[0] = 1'b0; sr[0] = 1'b1; exp[0] = 8'h55;
    init[1] = 8'h55; md[1] = 3'b011; sl[1] = 1'b0; sr[1] = 1'b1; exp[1] = 8'h2A;
    init[2] = 8'h81; md[2] = 3'b100; sl[2] = 1'b0; sr[2] = 1'b0; exp[2] = 8'h03;
    init[3] = 8'h81; md[3] = 3'b101; sl[3] = 1'b1; sr[3] = 1'b1; exp[3] = 8'hC0;
    init[4] = 8'h5A; md[4] = 3'b110; sl[4] = 1'b1; sr[4] = 1'b1; exp[4] = 8'h00;
    init[5] = 8'h0F; md[5] = 3'b111; sl[5] = 1'b0; sr[5] = 1'b0; exp[5] = 8'hF0;
    for (int i = 0; i < 6; i++) begin
      load(init[i]);
      enable = 1'b1; mode = md[i]; ser_in_l = sl[i]; ser_in_r = sr[i];
      step();
      enable = 1'b0; ser_in_l = 1'b0; ser_in_r = 1'b0;
      checks++;
      if (data_out !== exp[i]) begin
        errors++; $display("FAIL mode_%0d: got %h want %h", md[i], data_out, exp[i]);
      end
    end
  endtask

  task automatic test_auto_shift();
    logic [7:0] seq [3];
    seq[0] = 8'hC0; seq[1] = 8'h60; seq[2] = 8'h30;
    load(8'h81);
    start = 1'b1; mode = 3'b101; shift_cnt = 4'd3;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || data_out !== 8'h81) begin
      errors++; $display("FAIL auto_accept: busy=%b done=%b data=%h want 1 0 81", busy, done, data_out); end
    // Load attempt held across every step of the run.
    enable = 1'b1; mode = 3'b001; data_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (data_out !== seq[i] || busy !== (i < 2) || done !== (i == 2)) begin
        errors++; $display("FAIL auto_step%0d: data=%h busy=%b done=%b want %h %b %b",
                           i, data_out, busy, done, seq[i], (i < 2), (i == 2));
      end
    end
    enable = 1'b0;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h30) begin
      errors++; $display("FAIL auto_after: data=%h busy=%b done=%b want 30 0 0", data_out, busy, done); end
  endtask

  task automatic test_reject();
    start = 1'b1; mode = 3'b010; shift_cnt = 4'd0;
    step();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || data_out !== 8'h30) begin
      errors++; $display("FAIL reject_cnt0: data=%h busy=%b done=%b want 30 0 1", data_out, busy, done); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reject_cnt0_after: busy=%b done=%b want 0 0", busy, done); end
    start = 1'b1; enable = 1'b1; mode = 3'b001; data_in = 8'hAB; shift_cnt = 4'd4;
    step();
    start = 1'b0; enable = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || data_out !== 8'h30) begin
      errors++; $display("FAIL reject_mode: data=%h busy=%b done=%b want 30 0 1", data_out, busy, done); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h30) begin
      errors++; $display("FAIL reject_mode_after: data=%h busy=%b done=%b want 30 0 0", data_out, busy, done); end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    start = 1'b1; mode = 3'b100; shift_cnt = 4'd1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || data_out !== 8'h01) begin
      errors++; $display("FAIL b2b_first_accept: data=%h busy=%b want 01 1", data_out, busy); end
    step();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || data_out !== 8'h02) begin
      errors++; $display("FAIL b2b_first_done: data=%h busy=%b done=%b want 02 0 1", data_out, busy, done); end
    start = 1'b1; mode = 3'b100; shift_cnt = 4'd2;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || data_out !== 8'h02) begin
      errors++; $display("FAIL b2b_second_accept: data=%h busy=%b done=%b want 02 1 0", data_out, busy, done); end
    step();
    checks++; if (busy !== 1'b1 || data_out !== 8'h04) begin
      errors++; $display("FAIL b2b_step1: data=%h busy=%b want 04 1", data_out, busy); end
    step();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || data_out !== 8'h08) begin
      errors++; $display("FAIL b2b_second_done: data=%h busy=%b done=%b want 08 0 1", data_out, busy, done); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: got %b want 0", done); end
  endtask

  task automatic test_reset_mid_run();
    load(8'hFF);
    start = 1'b1; mode = 3'b010; ser_in_r = 1'b0; shift_cnt = 4'd5;
    step();
    start = 1'b0;
    step();
    step();
    checks++; if (data_out !== 8'hFC || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_before: data=%h busy=%b want FC 1", data_out, busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: data=%h busy=%b done=%b want 00 0 0", data_out, busy, done); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
        errors++; $display("FAIL midrun_quiet%0d: data=%h busy=%b done=%b want 00 0 0", i, data_out, busy, done);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_hold();
    test_modes();
    test_auto_shift();
    test_reject();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
